farrow_interp_nch: RTL
======================

Name: farrow_interp_nch

Overview:
Parametrised multi-channel Farrow interpolator (piecewise-parabolic, alpha = 0.5) for the QPSK receiver timing-recovery loop. It accepts NCH parallel baseband streams, for example I and Q. Each channel is interpolated at a per-sample fractional interval mu supplied by the loop controller. The block adds input valid, output valid, warm-up suppression, mu clamping, rounding and saturation, and a fixed 3-cycle pipeline.

Parameters:
NCH, 2, number of channels sharing one mu.
DW, 15, signed input sample width.
MU_W, 16, unsigned mu width; value = mu / 2^(MU_W-1).
OUT_W, 20, signed output width.
OUT_FRAC, 2, fractional bits carried in the output.

Ports:
clk  in  1  sample-rate clock.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  new sample on all channels this cycle.
data_in  in  NCH*DW  packed signed samples; channel c is in bits [c*DW +: DW].
mu  in  MU_W  fractional interval; sampled together with in_valid.
out_valid  out  1  y_out is valid this cycle.
y_out  out  NCH*OUT_W  packed signed interpolants.

Behaviour:
- Reset:
  - rst = 1 at a clk edge clears delay lines, fill counter, mu and valid pipelines.
  - out_valid = 0, y_out = 0.
  - rst has priority over a simultaneous in_valid.
  - Reset mid-stream discards all in-flight results; out_valid is low from the next edge.
- Delay line:
  - Per channel x0..x3, where x0 is the newest sample.
  - Shifts only when in_valid = 1. When in_valid = 0 the line holds and no result is launched.
- Fill counter:
  - Saturating 0..4; increments on each accepted sample.
  - A result is launched only when the sample accepted this cycle makes the count reach 4, or the count is already 4.
  - So the first 3 samples after reset produce no out_valid.
- Mu handling:
  - Any mu >= 2^(MU_W-1) (i.e. mu >= 1.0) is clamped to 2^(MU_W-1)-1.
  - The clamped mu is pipelined alongside the data.
- Arithmetic (per channel):
  - f1 = 0.5(x0 - x1 - x2 + x3)
  - f2 = 1.5*x1 - 0.5(x0 + x2 + x3)
  - f3 = x2
  - y = (f1*mu + f2)*mu + f3, which interpolates between x2 (mu = 0) and x1 (mu -> 1).
  - Internals are full precision with no intermediate truncation.
  - f-terms are held as 2x integers; DW+3 bits suffices.
- Output scaling:
  - y_out = round-half-up(y * 2^OUT_FRAC), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Pipeline:
  - S1 registers f1, f2, f3 and mu.
  - S2 registers v = f1*mu + f2 and the S1 f3/mu.
  - S3 registers the rounded, saturated y and out_valid.
  - Latency is exactly 3 clk from the accepting edge; throughput is 1 result per accepted sample.
- No backpressure.
- y_out holds its last value while out_valid = 0.

Optional Feature:
FARROW_LINEAR_EN:
- Defined: adds input port lin_mode (1 bit), sampled with in_valid and pipelined alongside mu. When lin_mode = 1, f1 = 0, f2 = x1 - x2, f3 = x2 (linear interpolation); same latency, rounding and saturation.
- Undefined: the port is absent and the block is always parabolic.

Decomposition:
- Package farrow_pkg:
  - Derived widths: coefficient width DW+3, product widths, mu one-constant 2^(MU_W-1).
  - Round/saturate function.
  - Localparam for pipeline depth 3.
- Sub-module farrow_ch: one channel's delay line and S1-S3 datapath; instantiated NCH times by generate.
- Top level owns the fill counter, mu clamp, mu/lin_mode pipeline and valid pipeline.

Test Plan:
1. Reset: hold rst = 1 for 3 cycles with in_valid = 1 -> out_valid = 0 and all y_out = 0 throughout and 1 cycle after release.
2. Warm-up and latency: feed 4 samples in consecutive cycles after reset -> out_valid is first high exactly 3 clk after the 4th accepting edge, and never earlier.
3. DC: all channels constant 1000, mu = 0x4000 -> every y_out = 4000 on every valid cycle.
4. Ramp on ch0 (x3..x0 = 0, 1, 2, 3):
   - mu = 0x4000 -> 6.
   - mu = 0 -> 4.
   - mu = 0x8000 (clamped) -> 8.
   - Ch1 is fed negated data -> -6, -4, -8.
5. Saturation (OUT_W = 17): x0 = x3 = 16383, x1 = x2 = -16384, mu = 0x4000 -> y_out = -65536.
6. Gaps and mid-run reset:
   - in_valid toggling 1/0 -> exactly one out_valid per accepted sample, with delay-line state preserved across gaps.
   - Assert rst mid-stream -> out_valid low next cycle, and the 4-sample warm-up restarts.

Source files
------------

// File: rtl/farrow_pkg.sv
// Shared widths, pipeline depth and the output round/saturate helper for
// the multi-channel Farrow interpolator.
package farrow_pkg;

  // Depth of the arithmetic pipeline, from the accepting edge to y_out.
  localparam int PIPE_DEPTH = 3;

  // The f-terms are stored doubled, so the 0.5 factors stay integral.
  // The worst case is 3*x1 - (x0+x2+x3), which needs DW+3 bits.
  function automatic int coef_w(input int dw);
    return dw + 3;
  endfunction

  // Width of v = F1*mu + F2*2^(MU_W-1). The product is CW+MU_W bits and
  // the sum adds one more.
  function automatic int v_w(input int dw, input int mu_w);
    return coef_w(dw) + mu_w + 1;
  endfunction

  // Width of Y = V*mu + F3*2^(2*(MU_W-1)).
  function automatic int y_w(input int dw, input int mu_w);
    return v_w(dw, mu_w) + mu_w + 1;
  endfunction

  // mu == 1.0 in the fixed-point domain of mu.
  function automatic longint mu_one(input int mu_w);
    return longint'(1) << (mu_w - 1);
  endfunction

  // Round half up after dropping 'shift' LSBs, then clamp to a signed
  // out_w-bit range. The caller truncates the result to out_w bits.
  function automatic logic signed [63:0] rnd_sat(input logic signed [63:0] y,
                                                 input int shift,
                                                 input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (y + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/farrow_interp_nch_ch.sv
// One channel of the Farrow interpolator: a three-tap history plus the
// S1..S3 datapath. The incoming sample is x0 of the window, so S1 already
// sees the shifted window on the accepting edge.
module farrow_interp_nch_ch
  import farrow_pkg::*;
#(
  parameter int DW       = 15,
  parameter int MU_W     = 16,
  parameter int OUT_W    = 20,
  parameter int OUT_FRAC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift,
  input  logic                    lin,
  input  logic signed [DW-1:0]    din,
  input  logic [MU_W-2:0]         mu1,
  input  logic [MU_W-2:0]         mu2,
  input  logic                    en3,
  output logic signed [OUT_W-1:0] y
);

  localparam int CW = coef_w(DW);
  localparam int VW = v_w(DW, MU_W);
  localparam int YW = y_w(DW, MU_W);
  localparam int M  = MU_W - 1;
  // Y carries 2 * 2^(2M) * y, so the output drops 2M+1-OUT_FRAC LSBs.
  localparam int SH = 2 * M + 1 - OUT_FRAC;

  logic signed [DW-1:0] t0, t1, t2;   // x1, x2, x3 of the next window
  logic signed [CW-1:0] f1_c, f2_c, f3_c;
  logic signed [CW-1:0] f1_r, f2_r, f3_r, f3_r2;
  logic signed [VW-1:0] v_c, v_r;
  logic signed [YW-1:0] y_c;
  logic signed [MU_W-1:0] m1s, m2s;

  assign m1s = {1'b0, mu1};
  assign m2s = {1'b0, mu2};

  // Doubled coefficients from the window {din, t0, t1, t2}.
  always_comb begin
    f3_c = CW'(t1) <<< 1;
    if (lin) begin
      f1_c = '0;
      f2_c = (CW'(t0) - CW'(t1)) <<< 1;
    end else begin
      f1_c = CW'(din) - CW'(t0) - CW'(t1) + CW'(t2);
      f2_c = (CW'(t0) <<< 1) + CW'(t0) - CW'(din) - CW'(t1) - CW'(t2);
    end
  end

  // Full-precision Horner steps. No truncation happens before rounding.
  always_comb begin
    v_c = VW'(f1_r) * VW'(m1s) + (VW'(f2_r) <<< M);
    y_c = YW'(v_r) * YW'(m2s) + (YW'(f3_r2) <<< (2 * M));
  end

  // The history advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      t0 <= '0;
      t1 <= '0;
      t2 <= '0;
    end else if (shift) begin
      t0 <= din;
      t1 <= t0;
      t2 <= t1;
    end
  end

  // S1..S3 registers. Only the output stage is qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      f1_r  <= '0;
      f2_r  <= '0;
      f3_r  <= '0;
      f3_r2 <= '0;
      v_r   <= '0;
      y     <= '0;
    end else begin
      f1_r  <= f1_c;
      f2_r  <= f2_c;
      f3_r  <= f3_c;
      v_r   <= v_c;
      f3_r2 <= f3_r;
      if (en3) y <= OUT_W'(rnd_sat(64'(y_c), SH, OUT_W));
    end
  end

endmodule

// File: rtl/farrow_interp_nch.sv
// Multi-channel piecewise-parabolic Farrow interpolator (alpha = 0.5).
// All channels share one mu. The block has a fixed 3-cycle latency and no
// backpressure.
// Optional build macro FARROW_LINEAR_EN adds the lin_mode input, which
// selects linear interpolation.
module farrow_interp_nch
  import farrow_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DW       = 15,
  parameter int MU_W     = 16,
  parameter int OUT_W    = 20,
  parameter int OUT_FRAC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NCH*DW-1:0]    data_in,
  input  logic [MU_W-1:0]      mu,
`ifdef FARROW_LINEAR_EN
  input  logic                 lin_mode,
`endif
  output logic                 out_valid,
  output logic [NCH*OUT_W-1:0] y_out
);

  logic [2:0]            fill;
  logic                  launch;
  logic                  lin;
  logic [MU_W-2:0]       mu_c, mu_s1, mu_s2;
  logic [PIPE_DEPTH-1:0] vld_pipe;

`ifdef FARROW_LINEAR_EN
  assign lin = lin_mode;
`else
  assign lin = 1'b0;
`endif

  // Any mu at or above 1.0 saturates to the largest fraction.
  assign mu_c = mu[MU_W-1] ? {(MU_W-1){1'b1}} : mu[MU_W-2:0];

  // A result launches once this sample completes a 4-sample window.
  assign launch = in_valid && (fill >= 3'd3);

  // Saturating fill count of accepted samples since reset.
  always_ff @(posedge clk) begin
    if (rst)                            fill <= '0;
    else if (in_valid && fill != 3'd4)  fill <= fill + 3'd1;
  end

  // Valid and mu travel alongside the channel datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      mu_s1    <= '0;
      mu_s2    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_DEPTH-2:0], launch};
      mu_s1    <= mu_c;
      mu_s2    <= mu_s1;
    end
  end

  assign out_valid = vld_pipe[PIPE_DEPTH-1];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    farrow_interp_nch_ch #(
      .DW(DW), .MU_W(MU_W), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .shift(in_valid),
      .lin  (lin),
      .din  (data_in[c*DW +: DW]),
      .mu1  (mu_s1),
      .mu2  (mu_s2),
      .en3  (vld_pipe[PIPE_DEPTH-2]),
      .y    (y_out[c*OUT_W +: OUT_W])
    );
  end

endmodule
